// File: rtl/rf_wb_arbiter_pkg.sv
// Shared register-file writeback definitions: default widths and the source
// encoding also used by the issue stage.
package rf_wb_arbiter_pkg;

  localparam int RF_DATA_WIDTH  = 32;
  localparam int RF_REG_NUM     = 32;
  localparam int RF_REG_NUM_BIT = 5;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write busy vector: one bit per register, set on reservation, cleared
// on commit, with set winning a same-edge collision. Register 0 never goes busy.
module rf_scoreboard #(
  parameter int REG_NUM     = 32,
  parameter int REG_NUM_BIT = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   set_en,
  input  logic [REG_NUM_BIT-1:0] set_idx,
  input  logic                   clr_en,
  input  logic [REG_NUM_BIT-1:0] clr_idx,
  output logic [REG_NUM-1:0]     busy
);

  logic [REG_NUM-1:0] set_mask;
  logic [REG_NUM-1:0] clr_mask;
  logic [REG_NUM-1:0] busy_next;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
    busy_next    = (busy & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter merging the ALU (A) and long-latency (B) result
// paths into the single register-file write port, plus the pending-write scoreboard.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = RF_DATA_WIDTH,
  parameter int REG_NUM     = RF_REG_NUM,
  parameter int REG_NUM_BIT = RF_REG_NUM_BIT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [REG_NUM_BIT-1:0] a_rd,
  input  logic [DATA_WIDTH-1:0]  a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [REG_NUM_BIT-1:0] b_rd,
  input  logic [DATA_WIDTH-1:0]  b_data,
  input  logic                   resv_valid,
  input  logic [REG_NUM_BIT-1:0] resv_rd,
  output logic                   wen,
  output logic [REG_NUM_BIT-1:0] waddr,
  output logic [DATA_WIDTH-1:0]  wdata,
  output logic [REG_NUM-1:0]     busy
);

  logic                   last_grant;
  logic                   xfer;
  logic [REG_NUM_BIT-1:0] sel_rd;
  logic [DATA_WIDTH-1:0]  sel_data;

  // Under contention the source that did not win last time gets the port.
  always_comb begin
    a_ready  = a_valid && !(b_valid && (last_grant == SRC_A));
    b_ready  = b_valid && !(a_valid && (last_grant == SRC_B));
    xfer     = a_ready || b_ready;
    sel_rd   = a_ready ? a_rd   : b_rd;
    sel_data = a_ready ? a_data : b_data;
  end

  // Reset leaves last_grant at B so A wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= SRC_B;
      wen        <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
    end else begin
      wen <= 1'b0;
      if (xfer) begin
        last_grant <= a_ready ? SRC_A : SRC_B;
        if (sel_rd != '0) begin
          wen   <= 1'b1;
          waddr <= sel_rd;
          wdata <= sel_data;
        end
      end
    end
  end

  // The clear lands on the edge that ends the wen cycle, i.e. the commit edge.
  rf_scoreboard #(
    .REG_NUM     (REG_NUM),
    .REG_NUM_BIT (REG_NUM_BIT)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (resv_valid && (resv_rd != '0)),
    .set_idx (resv_rd),
    .clr_en  (wen),
    .clr_idx (waddr),
    .busy    (busy)
  );

endmodule
